// File: rtl/lif_neuron_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lif_neuron_stage
// Purpose  : Leaky integrate-and-fire neuron stage. Integrates signed synaptic
//            weight beats into a saturating 24-bit membrane potential. At the
//            end of each timestep it applies the leak, decides whether to spike
//            and emits one registered 32-bit result word:
//              {spike, rflag, ts[5:0], leaked[23:0]}
// Ports    : clk        - sole clock, rising edge
//            reset      - synchronous, active-low reset
//            in_valid   - weight beat valid
//            in_ready   - stage accepts a beat this cycle (INTEG only)
//            in_weight  - signed 16-bit synaptic weight
//            in_last    - beat closes the current timestep
//            out_valid  - result word valid
//            out_ready  - downstream accepts the result word
//            out_data   - registered 32-bit result word
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_stage #(
    parameter logic signed [23:0] THRESH     = 24'sd1000,
    parameter int                 LEAK_SHIFT = 3,
    parameter int                 REFRAC     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_weight,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data
);

    localparam logic [3:0]         c_REFRAC_LOAD = 4'(REFRAC);
    localparam logic signed [23:0] c_POT_MAX     = 24'sh7FFFFF;
    localparam logic signed [23:0] c_POT_MIN     = 24'sh800000;

    typedef enum logic [1:0] {
        ST_INTEG = 2'd0,
        ST_FIRE  = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic signed [23:0] r_pot;
    logic [3:0]         r_refrac;
    logic [5:0]         r_ts;

    logic               w_accept;
    logic signed [24:0] w_sum;
    logic signed [23:0] w_sat;
    logic signed [23:0] w_leak_part;
    logic signed [23:0] w_leaked;
    logic [23:0]        w_leaked_out;
    logic               w_refrac_active;
    logic               w_spike;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_INTEG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            ST_INTEG: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_state_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_state_next = ST_INTEG;
                end
            end
            default: begin
                w_state_next = ST_INTEG;
            end
        endcase
    end

    assign w_accept        = in_valid && in_ready;
    assign w_refrac_active = (r_refrac != 4'd0);

    // Saturating add: one guard bit is enough for a 24-bit + 16-bit sum;
    // disagreement between the guard bit and bit 23 means overflow.
    assign w_sum = {r_pot[23], r_pot} + {{9{in_weight[15]}}, in_weight};
    always_comb begin
        w_sat = w_sum[23:0];
        if (w_sum[24] != w_sum[23]) begin
            w_sat = w_sum[24] ? c_POT_MIN : c_POT_MAX;
        end
    end

    // Leak toward zero by a power-of-two fraction. The result magnitude never
    // exceeds |pot|, so it always fits in 24 bits.
    assign w_leak_part  = r_pot >>> LEAK_SHIFT;
    assign w_leaked     = r_pot - w_leak_part;
    assign w_spike      = !w_refrac_active && (w_leaked >= THRESH);
    assign w_leaked_out = w_refrac_active ? 24'd0 : w_leaked;

    // ------------------------------------------------------------------
    // Datapath: potential, refractory counter, timestep, result word
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pot     <= 24'sd0;
            r_refrac  <= 4'd0;
            r_ts      <= 6'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            case (r_state)
                ST_INTEG: begin
                    // Weights arriving while refractory are dropped.
                    if (w_accept && !w_refrac_active) begin
                        r_pot <= w_sat;
                    end
                end
                ST_FIRE: begin
                    out_valid <= 1'b1;
                    out_data  <= {w_spike, w_refrac_active, r_ts, w_leaked_out};
                    if (w_refrac_active) begin
                        r_pot    <= 24'sd0;
                        r_refrac <= r_refrac - 4'd1;
                    end else if (w_spike) begin
                        r_pot    <= 24'sd0;
                        r_refrac <= c_REFRAC_LOAD;
                    end else begin
                        r_pot    <= w_leaked;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_ts      <= r_ts + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_stage
// Purpose  : Self-checking bench for lif_neuron_stage. Stimulus pushes the
//            expected result word of every timestep into a queue; a separate
//            monitor pops and compares each word the DUT hands off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_stage;

    localparam int THRESH     = 1000;
    localparam int LEAK_SHIFT = 3;
    localparam int REFRAC     = 2;

    logic               clk       = 1'b0;
    logic               reset     = 1'b0;
    logic               in_valid  = 1'b0;
    logic signed [15:0] in_weight = 16'sd0;
    logic               in_last   = 1'b0;
    logic               out_ready = 1'b1;
    logic               in_ready;
    logic               out_valid;
    logic [31:0]        out_data;

    lif_neuron_stage #(
        .THRESH     (24'sd1000),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          cur_w[$];
    bit          mon_en     = 1'b0;
    bit          rand_ready = 1'b0;
    bit          hold_ready = 1'b0;

    // Behavioural neuron state
    int m_pot    = 0;
    int m_refrac = 0;
    int m_ts     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic int floor_div_pow2(input int v);
        int d;
        int q;
        d = 1 << LEAK_SHIFT;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        return q;
    endfunction

    // One timestep of the neuron, applied to the weights in cur_w.
    function automatic logic [31:0] model_step();
        int          leaked;
        bit          spike;
        bit          rflag;
        logic [31:0] wd;
        foreach (cur_w[i]) begin
            if (m_refrac == 0) begin
                m_pot = m_pot + cur_w[i];
                if (m_pot > 8388607)  m_pot = 8388607;
                if (m_pot < -8388608) m_pot = -8388608;
            end
        end
        leaked = m_pot - floor_div_pow2(m_pot);
        rflag  = (m_refrac > 0);
        spike  = !rflag && (leaked >= THRESH);
        wd[31]    = spike;
        wd[30]    = rflag;
        wd[29:24] = m_ts[5:0];
        wd[23:0]  = rflag ? 24'd0 : leaked[23:0];
        if (rflag) begin
            m_pot    = 0;
            m_refrac = m_refrac - 1;
        end else if (spike) begin
            m_pot    = 0;
            m_refrac = REFRAC;
        end else begin
            m_pot = leaked;
        end
        m_ts = (m_ts + 1) % 64;
        return wd;
    endfunction

    function automatic void model_reset();
        m_pot    = 0;
        m_refrac = 0;
        m_ts     = 0;
    endfunction

    // Downstream ready generator
    always @(negedge clk) begin
        if (hold_ready)      out_ready = 1'b0;
        else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = 1'b1;
    end

    // Monitor: compares the presented word every cycle it is valid; pops on handshake.
    always begin
        @(negedge clk);
        #1;
        if (mon_en && reset && out_valid) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h, expected no word", out_data);
            end else if (out_ready) begin
                check("word", out_data, exp_q.pop_front());
            end else begin
                check("word_hold", out_data, exp_q[0]);
            end
        end
    end

    task automatic send_beat(input int w, input bit last);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        in_weight = w[15:0];
        in_last   = last;
        guard     = 0;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) fail_now("beat_accept");
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Issue one timestep from cur_w; expected word is either the model's or a fixed value.
    task automatic run_ts(input bit use_const, input logic [31:0] cval, input bit gaps);
        logic [31:0] wd;
        wd = model_step();
        exp_q.push_back(use_const ? cval : wd);
        foreach (cur_w[i]) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 2));
            send_beat(cur_w[i], i == cur_w.size() - 1);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) fail_now("drain");
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) fail_now("wait_valid");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", out_data, 32'h0000_0000);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Sub-threshold timestep plus latency check
        cur_w = '{400, 400, 300};
        run_ts(1'b1, 32'h0000_03C3, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("latency_fire_valid", {31'd0, out_valid}, 32'd0);
        check("latency_fire_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("latency_emit_valid", {31'd0, out_valid}, 32'd1);

        // Fire, then refractory timesteps, then fire again
        cur_w = '{1200};
        run_ts(1'b1, 32'h8100_0765, 1'b0);
        cur_w = '{5000};
        run_ts(1'b1, 32'h4200_0000, 1'b0);
        run_ts(1'b1, 32'h4300_0000, 1'b0);
        run_ts(1'b1, 32'h8400_1117, 1'b0);
        idle(1);
        drain();

        // Positive saturation from reset
        do_reset();
        cur_w.delete();
        for (int i = 0; i < 300; i++) cur_w.push_back(32767);
        cur_w.push_back(0);
        run_ts(1'b1, 32'h8070_0000, 1'b0);
        idle(1);
        drain();

        // Negative saturation from reset, then a sub-threshold step
        do_reset();
        cur_w.delete();
        for (int i = 0; i < 300; i++) cur_w.push_back(-32768);
        cur_w.push_back(-5);
        run_ts(1'b0, 32'd0, 1'b0);
        cur_w = '{-16};
        run_ts(1'b0, 32'd0, 1'b0);
        idle(1);
        drain();

        // Backpressure: word must hold, beats during EMIT are ignored
        hold_ready = 1'b1;
        @(negedge clk);
        cur_w = '{100, -50, 200};
        run_ts(1'b0, 32'd0, 1'b0);
        idle(1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_weight = 16'sd1234;
            in_last   = 1'b1;
        end
        idle(1);
        hold_ready = 1'b0;
        drain();

        // Reset in the middle of EMIT: no word, timestep restarts at 0
        hold_ready = 1'b1;
        @(negedge clk);
        cur_w = '{700, 700};
        run_ts(1'b0, 32'd0, 1'b0);
        idle(1);
        wait_valid();
        idle(2);
        do_reset();
        hold_ready = 1'b0;
        cur_w = '{50};
        run_ts(1'b1, 32'h0000_002C, 1'b0);
        idle(1);
        drain();

        // Randomized timesteps with random downstream backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            int nb;
            nb = $urandom_range(1, 6);
            cur_w.delete();
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0)
                    cur_w.push_back(int'($signed(16'($urandom))));
                else
                    cur_w.push_back(int'($urandom_range(0, 900)) - 200);
            end
            run_ts(1'b0, 32'd0, 1'b1);
        end
        idle(1);
        drain();
        rand_ready = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_neuron_stage.md
LIF_NEURON_STAGE -- requirements
Module: lif_neuron_stage

Purpose: leaky integrate-and-fire stage. It accumulates synaptic weight beats and emits one 32-bit result word per timestep into neuronalpipes (`in_data`).

Interface
REQ-001 Parameter THRESH, default 24'sd1000, signed firing threshold.
REQ-002 Parameter LEAK_SHIFT, default 3, leak divisor exponent (range 1..23).
REQ-003 Parameter REFRAC, default 2, refractory length in timesteps (range 0..15).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-006 in_valid  input  1  weight beat valid.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_weight  input  16  signed synaptic weight.
REQ-009 in_last  input  1  beat closes the current timestep.
REQ-010 out_valid  output  1  result word valid.
REQ-011 out_ready  input  1  downstream accepts the result word.
REQ-012 out_data  output  32  result word, registered.

Function
REQ-013 The FSM SHALL have states INTEG, FIRE and EMIT; reset enters INTEG.
REQ-014 In INTEG, in_ready SHALL be 1; in FIRE and EMIT, in_ready SHALL be 0.
REQ-015 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-016 Accepted beat with refrac_cnt=0: pot SHALL become sat24(pot + sign-extended in_weight).
REQ-017 Accepted beat with refrac_cnt>0: the weight SHALL be discarded and pot left unchanged.
REQ-018 sat24 SHALL clamp to 0x7FFFFF and 0x800000; wrap-around is never permitted.
REQ-019 An accepted beat with in_last=1 SHALL move INTEG to FIRE; its weight is included per REQ-016/017.
REQ-020 In FIRE, leaked SHALL equal pot - (pot >>> LEAK_SHIFT), using arithmetic shift (e.g. -16, shift 2 gives -12).
REQ-021 FIRE with refrac_cnt>0 SHALL give: spike=0, rflag=1, pot:=0, refrac_cnt decremented.
REQ-022 FIRE with refrac_cnt=0 and leaked>=THRESH (signed compare) SHALL give: spike=1, rflag=0, pot:=0, refrac_cnt:=REFRAC.
REQ-023 FIRE in all other cases SHALL give: spike=0, rflag=0, pot:=leaked.
REQ-024 FIRE SHALL register out_data = {spike, rflag, ts[5:0], leaked[23:0]}, with leaked forced to 0 when rflag=1.
REQ-025 FIRE SHALL set out_valid=1 and move to EMIT.
REQ-026 Latency: last beat accepted at edge N gives out_valid=1 after edge N+1.
REQ-027 In EMIT, out_valid and out_data SHALL hold stable until out_ready=1 on an edge.
REQ-028 On that handshake edge: out_valid:=0, ts:=ts+1 (mod 64, wrapping 63 to 0), return to INTEG.
REQ-029 in_valid asserted during FIRE/EMIT SHALL have no effect on any state.

Reset
REQ-030 reset=0 at an edge SHALL force: state INTEG, pot=0, refrac_cnt=0, ts=0, out_valid=0, out_data=0.
REQ-031 Reset SHALL abort any operation in progress, including mid-EMIT, with no word emitted; in_ready=1 from the first cycle after reset deasserts.

Verification (THRESH=1000, LEAK_SHIFT=3, REFRAC=2)
REQ-032 Reset: hold reset=0 for 2 edges -> out_valid=0, out_data=0x00000000, in_ready=1.
REQ-033 Sub-threshold: beats 400, 400, 300(last) -> pot 1100, leaked 963, out_data=0x000003C3 two cycles after the last beat.
REQ-034 Fire: continuing from REQ-033 (handshaken), beat 1200(last) -> pot 2163, leaked 1893, out_data=0x81000765, pot becomes 0.
REQ-035 Refractory: next two timesteps, each 5000(last) -> out_data 0x42000000 then 0x43000000. Third timestep 5000(last) -> 0x84001117 (leaked 4375).
REQ-036 Saturation: from reset, 300 beats of 32767 then 0(last) -> pot clamps to 0x7FFFFF, leaked 0x700000, out_data=0x80700000.
REQ-037 Backpressure/reset: out_ready=0 for 5 cycles -> out_data stable, in_ready=0, beats ignored. reset=0 during EMIT -> out_valid=0 next cycle, ts restarts at 0.
